// File: rtl/ads1675_pkg.sv
// rtl/ads1675_pkg.sv - shared constants and types for the ADS1675 output emulator
package ads1675_pkg;

  localparam int DW_DEF          = 24;
  localparam int FRAME_SCLKS_DEF = 48;
  localparam int SCLK_DIV_DEF    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } ads1675_tx_state_t;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ads1675_sclk_gen.sv
// rtl/ads1675_sclk_gen.sv - free-running sclk divider with a strobe on each sclk rise
module ads1675_sclk_gen
  import ads1675_pkg::*;
#(
  parameter int SCLK_DIV = SCLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic sclk_o,
  output logic rise_stb
);

  localparam int DCW = cnt_width(SCLK_DIV);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(SCLK_DIV - 1);
  localparam logic [DCW-1:0] DIV_HALF = DCW'(SCLK_DIV / 2);

  logic [DCW-1:0] div_cnt;
  logic [DCW-1:0] div_nxt;

  assign rise_stb = (div_cnt == DIV_LAST);
  assign div_nxt  = rise_stb ? '0 : div_cnt + 1'b1;

  // sclk is registered from the next count so the pin never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= DIV_LAST;
      sclk_o  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      sclk_o  <= (div_nxt < DIV_HALF);
    end
  end

endmodule

// File: rtl/ads1675_emulator_tx.sv
// rtl/ads1675_emulator_tx.sv - serializes stream samples into an ADS1675-style SCLK/DRDY/DOUT frame
module ads1675_emulator_tx
  import ads1675_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int SCLK_DIV    = SCLK_DIV_DEF,
  parameter int FRAME_SCLKS = FRAME_SCLKS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic          sclk_o,
  output logic          drdy_o,
  output logic          dout_o,
  output logic          underrun_o,
  output logic [15:0]   underrun_cnt
);

  localparam int BCW = cnt_width(FRAME_SCLKS);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_SCLKS - 1);

  ads1675_tx_state_t state, state_nxt;
  logic [BCW-1:0]    bit_cnt;
  logic [DW-1:0]     hold_data;
  logic              hold_valid;
  logic [DW-1:0]     shift_q;
  logic              rise_stb;
  logic              handshake;
  logic              frame_end;
  logic              frame_start;

  ads1675_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .sclk_o   (sclk_o),
    .rise_stb (rise_stb)
  );

  assign handshake   = s_axis_tvalid & s_axis_tready;
  assign frame_end   = (state == FRAME) && (bit_cnt == BIT_LAST);
  assign frame_start = rise_stb && en && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start)                state_nxt = FRAME;
    else if (rise_stb && frame_end) state_nxt = IDLE;
  end

  always_comb begin
    drdy_o = 1'b0;
    dout_o = 1'b0;
    if (state == FRAME) begin
      drdy_o = (bit_cnt == '0);
      dout_o = shift_q[DW-1];
    end
  end

  // Zeros shift in behind the sample, so dout is 0 for the tail of the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= '0;
      shift_q       <= '0;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      s_axis_tready <= 1'b0;
      underrun_o    <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      underrun_o    <= 1'b0;
      s_axis_tready <= frame_start | ~(hold_valid | handshake);
      if (frame_start) begin
        bit_cnt <= '0;
        if (hold_valid) begin
          shift_q    <= hold_data;
          hold_valid <= 1'b0;
        end else if (handshake) begin
          shift_q <= s_axis_tdata;
        end else begin
          shift_q    <= '0;
          underrun_o <= 1'b1;
          if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end
      end else begin
        if (rise_stb && (state == FRAME) && !frame_end) begin
          bit_cnt <= bit_cnt + 1'b1;
          shift_q <= {shift_q[DW-2:0], 1'b0};
        end
        if (handshake) begin
          hold_data  <= s_axis_tdata;
          hold_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ads1675_emulator_tx.sv
// tb/tb_ads1675_emulator_tx.sv - self-checking bench for ads1675_emulator_tx
module tb_ads1675_emulator_tx;

  logic        clk = 1'b0;
  logic        rst, en, tvalid;
  logic [23:0] tdata;
  logic        tready, sclk, drdy, dout, uflow;
  logic [15:0] uflow_cnt;

  logic        rst6, en6, tvalid6;
  logic [23:0] tdata6;
  logic        tready6, sclk6, drdy6, dout6, uflow6;
  logic [15:0] uflow_cnt6;

  always #5 clk = ~clk;

  ads1675_emulator_tx dut (
    .clk(clk), .rst(rst), .en(en), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .sclk_o(sclk), .drdy_o(drdy), .dout_o(dout),
    .underrun_o(uflow), .underrun_cnt(uflow_cnt)
  );

  ads1675_emulator_tx #(.DW(24), .SCLK_DIV(4), .FRAME_SCLKS(25)) dut6 (
    .clk(clk), .rst(rst6), .en(en6), .s_axis_tdata(tdata6), .s_axis_tvalid(tvalid6),
    .s_axis_tready(tready6), .sclk_o(sclk6), .drdy_o(drdy6), .dout_o(dout6),
    .underrun_o(uflow6), .underrun_cnt(uflow_cnt6)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver model: samples drdy/dout on every sclk fall, frames of 48 bits, MSB first
  logic [23:0] rx_q[$];
  int          ones_q[$];
  int          rise_q[$];
  int          width_q[$];
  int          uflow_pulses = 0;
  logic        sclk_d = 1'b0, drdy_d = 1'b0, in_frame = 1'b0;
  int          bit_idx = 0, ones = 0, dhi = 0;
  logic [23:0] word = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      sclk_d   = 1'b0;
      drdy_d   = 1'b0;
      dhi      = 0;
    end else begin
      if (uflow) uflow_pulses++;
      if (drdy && !drdy_d) rise_q.push_back(cyc);
      if (drdy) dhi++;
      if (!drdy && drdy_d) begin
        width_q.push_back(dhi);
        dhi = 0;
      end
      if (sclk_d && !sclk) begin
        if (drdy) begin
          in_frame = 1'b1;
          bit_idx  = 0;
          ones     = 0;
          word     = '0;
        end
        if (in_frame) begin
          if (bit_idx < 24) word = {word[22:0], dout};
          ones += int'(dout);
          bit_idx++;
          if (bit_idx == 48) begin
            rx_q.push_back(word);
            ones_q.push_back(ones);
            in_frame = 1'b0;
          end
        end
      end
      sclk_d = sclk;
      drdy_d = drdy;
    end
  end

  task automatic push(input logic [23:0] d);
    int g = 0;
    tdata  = d;
    tvalid = 1'b1;
    while (!tready && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("push_wait", 64'(g < 500), 64'd1);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic drop_en_at_drdy();
    int g = 0;
    while (!drdy && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("drdy_wait", 64'(drdy), 64'd1);
    en = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int g = 0;
    while (rx_q.size() < n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("rx_wait", 64'(rx_q.size() >= n), 64'd1);
  endtask

  typedef struct {
    logic [23:0] sample;
    logic [23:0] exp_word;
    int          exp_ones;
  } vec_t;

  vec_t        vecs[5];
  logic [23:0] rnd[8];
  logic [24:0] mask, exp_mask;
  int          base, rbase, ubase, g, k, c0, c1, dcount, ocount;
  logic        sclk_prev;

  initial begin
    vecs[0] = '{24'hA5F00F, 24'hA5F00F, 12};
    vecs[1] = '{24'h800000, 24'h800000, 1};
    vecs[2] = '{24'h000001, 24'h000001, 1};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 24};
    vecs[4] = '{24'h123456, 24'h123456, 9};

    rst = 1'b1; en = 1'b0; tvalid = 1'b0; tdata = '0;
    rst6 = 1'b1; en6 = 1'b0; tvalid6 = 1'b0; tdata6 = '0;

    // Reset
    repeat (5) @(negedge clk);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_drdy", 64'(drdy), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_uflow", 64'(uflow), 64'd0);
    check("rst_ucnt", 64'(uflow_cnt), 64'd0);
    rst = 1'b0; rst6 = 1'b0;
    @(negedge clk);
    check("tready_after_rst", 64'(tready), 64'd1);
    check("tready6_after_rst", 64'(tready6), 64'd1);
    repeat (10) @(negedge clk);
    check("idle_ucnt", 64'(uflow_cnt), 64'd0);

    // Single frames from the vector table
    for (int i = 0; i < 5; i++) begin
      base = rx_q.size();
      push(vecs[i].sample);
      en = 1'b1;
      drop_en_at_drdy();
      wait_rx(base + 1);
      if (rx_q.size() > base) begin
        check($sformatf("vec%0d_word", i), 64'(rx_q[base]), 64'(vecs[i].exp_word));
        check($sformatf("vec%0d_ones", i), 64'(ones_q[base]), 64'(vecs[i].exp_ones));
      end
      if (width_q.size() > 0)
        check($sformatf("vec%0d_drdy_w", i), 64'(width_q[width_q.size()-1]), 64'd2);
    end

    // Back-to-back random samples, tvalid held
    repeat (20) @(negedge clk);
    for (int i = 0; i < 8; i++) rnd[i] = 24'($urandom);
    base = rx_q.size(); rbase = rise_q.size(); ubase = uflow_pulses;
    k = 0; g = 0;
    tdata = rnd[0]; tvalid = 1'b1; en = 1'b1;
    while (k < 8 && g < 2000) begin
      sclk_prev = tvalid & tready;
      @(negedge clk);
      g++;
      if (sclk_prev) begin
        k++;
        if (k < 8) tdata = rnd[k];
        else       tvalid = 1'b0;
      end
    end
    tvalid = 1'b0;
    check("b2b_pushes", 64'(k), 64'd8);
    g = 0;
    while (rise_q.size() < rbase + 8 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    en = 1'b0;
    wait_rx(base + 8);
    for (int i = 0; i < 8; i++)
      if (rx_q.size() > base + i) check($sformatf("b2b_word%0d", i), 64'(rx_q[base+i]), 64'(rnd[i]));
    for (int i = 1; i < 8; i++)
      if (rise_q.size() > rbase + i)
        check($sformatf("b2b_gap%0d", i), 64'(rise_q[rbase+i] - rise_q[rbase+i-1]), 64'd96);
    check("b2b_uflow", 64'(uflow_pulses - ubase), 64'd0);
    check("b2b_ucnt", 64'(uflow_cnt), 64'd0);

    // Underrun: three empty frames, then a real sample
    repeat (120) @(negedge clk);
    base = rx_q.size(); rbase = rise_q.size(); ubase = uflow_pulses;
    en = 1'b1;
    g = 0;
    while (rise_q.size() < rbase + 3 && g < 600) begin
      @(negedge clk);
      g++;
    end
    push(24'h800000);
    g = 0;
    while (rise_q.size() < rbase + 4 && g < 300) begin
      @(negedge clk);
      g++;
    end
    en = 1'b0;
    wait_rx(base + 4);
    for (int i = 0; i < 3; i++)
      if (rx_q.size() > base + i) check($sformatf("ur_word%0d", i), 64'(rx_q[base+i]), 64'd0);
    if (rx_q.size() > base + 3) check("ur_sample", 64'(rx_q[base+3]), 64'h800000);
    check("ur_pulses", 64'(uflow_pulses - ubase), 64'd3);
    check("ur_cnt", 64'(uflow_cnt), 64'd3);

    // en dropped at bit_cnt 10 with a sample pending in hold
    repeat (120) @(negedge clk);
    base = rx_q.size();
    push(24'h5A5A5A);
    en = 1'b1;
    g = 0;
    while (!drdy && g < 400) begin
      @(negedge clk);
      g++;
    end
    repeat (20) @(negedge clk);
    en = 1'b0;
    push(24'h3C3C3C);
    wait_rx(base + 1);
    dcount = 0; ocount = 0;
    repeat (300) begin
      @(negedge clk);
      dcount += int'(drdy);
      ocount += int'(dout);
    end
    check("endrop_drdy_idle", 64'(dcount), 64'd0);
    check("endrop_dout_idle", 64'(ocount), 64'd0);
    check("endrop_hold_full", 64'(tready), 64'd0);
    if (rx_q.size() > base) check("endrop_word", 64'(rx_q[base]), 64'h5A5A5A);
    en = 1'b1;
    drop_en_at_drdy();
    wait_rx(base + 2);
    if (rx_q.size() > base + 1) check("endrop_pending", 64'(rx_q[base+1]), 64'h3C3C3C);

    // SCLK_DIV=4, FRAME_SCLKS=25 instance
    tdata6 = 24'h000001; tvalid6 = 1'b1;
    @(negedge clk);
    tvalid6 = 1'b0;
    en6 = 1'b1;
    g = 0;
    while (!drdy6 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("d6_drdy", 64'(drdy6), 64'd1);
    check("d6_tready", 64'(tready6), 64'd1);
    c0 = cyc;
    tdata6 = 24'hFFFFFF; tvalid6 = 1'b1;
    sclk_prev = sclk6; k = 0; mask = '0; g = 0;
    while (k < 25 && g < 200) begin
      @(negedge clk);
      g++;
      tvalid6 = 1'b0;
      if (sclk_prev && !sclk6) begin
        if (dout6) mask[k] = 1'b1;
        k++;
      end
      sclk_prev = sclk6;
    end
    exp_mask = 25'd1 << 23;
    check("d6_falls", 64'(k), 64'd25);
    check("d6_mask", 64'(mask), 64'(exp_mask));
    g = 0;
    while (!drdy6 && g < 50) begin
      @(negedge clk);
      g++;
    end
    c1 = cyc;
    check("d6_frame_len", 64'(c1 - c0), 64'd100);
    repeat (20) @(negedge clk);
    check("d6_mid_dout", 64'(dout6), 64'd1);
    rst6 = 1'b1;
    @(negedge clk);
    check("d6_rst_out", 64'({sclk6, drdy6, dout6, tready6, uflow6}), 64'd0);
    check("d6_rst_cnt", 64'(uflow_cnt6), 64'd0);
    rst6 = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
